fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream.sv | 87 ++++++++
 tb/tb_fifo_rd_stream.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: issues pops on credit and streams the
// popped words out through a 3-entry valid/ready buffer, all in the rclk domain.
module fifo_rd_stream #(
   parameter int DSIZE = 8,
   parameter int CNTW  = 16
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic             m_valid,
   output logic [DSIZE-1:0] m_data,
   input  logic             m_ready,
   output logic [1:0]       buf_level,
   output logic [CNTW-1:0]  rd_count
);

   // Handshake: a word transfers on every rising edge where m_valid and m_ready
   // are both high; m_valid/m_data only change after a transfer or a new word.
   logic [DSIZE-1:0] buf_mem [3];
   logic [1:0]       head;
   logic [1:0]       tail;
   logic [1:0]       level;
   logic             inflight;
   logic             wr_en;
   logic             pop;
   logic [2:0]       credit_used;
   logic [2:0]       level_nxt;

   function automatic logic [1:0] wrap_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Credit counts the word still in the memory read pipeline, so rinc never
   // looks at the downstream side and a full buffer cannot be overrun.
   always_comb begin
      credit_used = {1'b0, level} + {2'b00, inflight};
      rinc        = rrst_n & ~rempty & (credit_used < 3'd3);
   end

   assign wr_en = inflight;
   assign pop   = m_valid & m_ready;

   always_comb begin
      level_nxt = {1'b0, level};
      if (wr_en && !pop) begin
         level_nxt = level_nxt + 3'd1;
      end else if (!wr_en && pop) begin
         level_nxt = level_nxt - 3'd1;
      end
   end

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         head     <= 2'd0;
         tail     <= 2'd0;
         level    <= 2'd0;
         inflight <= 1'b0;
         rd_count <= '0;
         for (int i = 0; i < 3; i++) begin
            buf_mem[i] <= '0;
         end
      end else begin
         inflight <= rinc;
         if (rinc) begin
            rd_count <= rd_count + CNTW'(1);
         end
         if (wr_en) begin
            buf_mem[tail] <= rdata;
            tail          <= wrap_inc(tail);
         end
         if (pop) begin
            head <= wrap_inc(head);
         end
         level <= level_nxt[1:0];
      end
   end

   assign m_valid   = (level != 2'd0);
   assign m_data    = buf_mem[head];
   assign buf_level = level;

   a_level_bound: assert property (@(posedge rclk) disable iff (!rrst_n)
      level_nxt <= 3'd3);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a model FIFO source feeds the DUT and a
// scoreboard monitor checks every delivered word in order.
module tb_fifo_rd_stream;

   logic       rclk;
   logic       rrst_n;
   logic       rempty;
   logic [7:0] rdata;
   logic       rinc;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready;
   logic [1:0] buf_level;
   logic [15:0] rd_count;

   logic       rinc4;
   logic       m_valid4;
   logic [7:0] m_data4;
   logic [1:0] buf_level4;
   logic [3:0] rd_count4;

   logic [7:0] src [64];
   int         rd_ptr;
   int         avail;
   int         exp_rd;
   logic [7:0] exp_q[$];
   int         n_tests;
   int         n_fail;
   logic       pop_s;

   fifo_rd_stream #(.DSIZE(8), .CNTW(16)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
      .rinc(rinc), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .buf_level(buf_level), .rd_count(rd_count)
   );

   fifo_rd_stream #(.DSIZE(8), .CNTW(4)) dut4 (
      .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
      .rinc(rinc4), .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready),
      .buf_level(buf_level4), .rd_count(rd_count4)
   );

   // clock / reset
   initial begin
      rclk = 1'b0;
      forever #5 rclk = ~rclk;
   end

   assign rempty = (rd_ptr >= avail);

   // FIFO source model: registered memory read, data one cycle after rinc
   initial begin
      rdata = 8'h00;
      forever begin
         @(negedge rclk);
         pop_s = rinc;
         @(posedge rclk);
         #1;
         if (pop_s) begin
            if (rd_ptr < 64) rdata = src[rd_ptr];
            rd_ptr++;
         end
      end
   end

   // scoreboard monitor
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge rclk);
         if (rrst_n && m_valid && m_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL stream_extra: got %02h, expected no word", m_data);
            end else begin
               e = exp_q.pop_front();
               if (m_data !== e) begin
                  n_fail++;
                  $display("FAIL stream_order: got %02h, expected %02h", m_data, e);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge rclk);
      #2;
   endtask

   task automatic load(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         src[avail + i] = base + 8'(i);
         exp_q.push_back(base + 8'(i));
      end
      avail  = avail + n;
      exp_rd = exp_rd + n;
   endtask

   task automatic wait_drain(input string name, input int max_cycles);
      int k;
      k = 0;
      while (!(exp_q.size() == 0 && rd_ptr >= avail && buf_level == 2'd0) && k < max_cycles) begin
         step();
         k++;
      end
      if (k >= max_cycles) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: %0d words still expected after %0d cycles", name, exp_q.size(), k);
      end
   endtask

   initial begin
      logic [7:0] rinc_exp;
      logic [7:0] mv_exp;
      int         pulses;
      n_tests = 0;
      n_fail  = 0;
      rd_ptr  = 0;
      avail   = 0;
      exp_rd  = 0;
      rrst_n  = 1'b0;
      m_ready = 1'b0;
      repeat (3) step();

      // reset state, with words already available
      load(8'hA1, 4);
      m_ready = 1'b1;
      @(negedge rclk);
      chk("reset_rinc_forced", {31'd0, rinc}, 32'd0);
      chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
      chk("reset_buf_level", {30'd0, buf_level}, 32'd0);
      chk("reset_m_data", {24'd0, m_data}, 32'd0);
      chk("reset_rd_count", {16'd0, rd_count}, 32'd0);

      // test 1: four words streamed with m_ready high
      step();
      rrst_n   = 1'b1;
      rinc_exp = 8'b0000_1111;
      mv_exp   = 8'b0011_1100;
      for (int i = 0; i < 8; i++) begin
         @(negedge rclk);
         chk($sformatf("t1_rinc_c%0d", i), {31'd0, rinc}, {31'd0, rinc_exp[i]});
         chk($sformatf("t1_m_valid_c%0d", i), {31'd0, m_valid}, {31'd0, mv_exp[i]});
         if (i >= 2 && i <= 5) begin
            chk($sformatf("t1_m_data_c%0d", i), {24'd0, m_data}, 32'hA1 + 32'(i - 2));
         end
      end
      step();
      chk("t1_rd_count", {16'd0, rd_count}, 32'(exp_rd));

      // test 2: backpressure with ten words available
      m_ready = 1'b0;
      load(8'hB0, 10);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge rclk);
         if (rinc) pulses++;
      end
      chk("t2_rinc_pulses", 32'(pulses), 32'd3);
      chk("t2_buf_level_full", {30'd0, buf_level}, 32'd3);
      chk("t2_rinc_held", {31'd0, rinc}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge rclk);
         chk($sformatf("t2_hold_valid_%0d", i), {31'd0, m_valid}, 32'd1);
         chk($sformatf("t2_hold_data_%0d", i), {24'd0, m_data}, 32'hB0);
      end
      step();
      m_ready = 1'b1;
      wait_drain("t2", 60);
      chk("t2_rd_count", {16'd0, rd_count}, 32'(exp_rd));

      // test 3: alternating m_ready with continuous supply
      load(8'hC0, 12);
      for (int i = 0; i < 80 && !(exp_q.size() == 0 && rd_ptr >= avail && buf_level == 2'd0); i++) begin
         step();
         m_ready = ~m_ready;
      end
      m_ready = 1'b1;
      wait_drain("t3", 20);
      chk("t3_rd_count", {16'd0, rd_count}, 32'(exp_rd));

      // test 4: FIFO runs empty after two words, then resumes
      step();
      load(8'hD0, 2);
      repeat (6) step();
      chk("t4_empty_m_valid", {31'd0, m_valid}, 32'd0);
      chk("t4_empty_buf_level", {30'd0, buf_level}, 32'd0);
      chk("t4_empty_rinc", {31'd0, rinc}, 32'd0);
      chk("t4_delivered_both", 32'(exp_q.size()), 32'd0);
      load(8'hD2, 1);
      wait_drain("t4", 20);
      chk("t4_rd_count", {16'd0, rd_count}, 32'(exp_rd));

      // test 5: reset while two words buffered and one in flight
      step();
      m_ready = 1'b0;
      load(8'hE0, 5);
      repeat (3) step();
      chk("t5_pre_level", {30'd0, buf_level}, 32'd2);
      chk("t5_pre_rinc", {31'd0, rinc}, 32'd0);
      rrst_n = 1'b0;
      exp_q.delete();
      rd_ptr = 0;
      avail  = 0;
      exp_rd = 0;
      step();
      rrst_n = 1'b1;
      chk("t5_post_m_valid", {31'd0, m_valid}, 32'd0);
      chk("t5_post_buf_level", {30'd0, buf_level}, 32'd0);
      chk("t5_post_rd_count", {16'd0, rd_count}, 32'd0);
      chk("t5_post_rd_count4", {28'd0, rd_count4}, 32'd0);
      chk("t5_post_rinc", {31'd0, rinc}, 32'd0);

      // test 6: 17 pops; the 4-bit counter wraps through 0 to 1
      m_ready = 1'b1;
      load(8'h10, 17);
      wait_drain("t6", 60);
      chk("t6_rd_count", {16'd0, rd_count}, 32'd17);
      chk("t6_rd_count_wrap", {28'd0, rd_count4}, 32'd1);

      repeat (3) step();
      chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
